// File: rtl/passcode_shift_check.sv
// Four-digit passcode checker with edge-detected digit entry,
// retry counting and a timed lockout after repeated failures.
module passcode_shift_check #(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Load,
  input  logic [3:0]  D,
  input  logic [15:0] Passcode,
  input  logic        Clear,
  output logic        Unlock,
  output logic        Error,
  output logic        Locked,
  output logic [2:0]  DigitCount
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_CHECK,
    S_UNLOCKED,
    S_LOCKED
  } state_t;

  localparam logic [2:0]  MaxT     = 3'(MAX_TRIES);
  localparam logic [15:0] LockInit = 16'(LOCK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  tries_q, tries_d;
  logic [15:0] lock_q, lock_d;
  logic        err_q, err_d;
  logic        load_q;

  logic        ld_edge;
  logic [2:0]  tries_inc;

  assign ld_edge   = Load & ~load_q;
  assign tries_inc = (tries_q >= MaxT) ? MaxT : tries_q + 3'd1;

  // State and datapath registers; LoadQ resets high so a held Load is not a digit
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      lock_q  <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      load_q  <= Load;
    end
  end

  // Next-state logic: collect digits, compare, then unlock or count a failure
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_COLLECT: begin
        if (Clear) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (ld_edge) begin
          sr_d  = {sr_q[11:0], D};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sr_q == Passcode) begin
          state_d = S_UNLOCKED;
          tries_d = '0;
        end else begin
          err_d   = 1'b1;
          sr_d    = '0;
          cnt_d   = '0;
          tries_d = tries_inc;
          if (tries_inc == MaxT) begin
            state_d = S_LOCKED;
            lock_d  = LockInit;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_UNLOCKED: begin
        if (Clear) begin
          state_d = S_COLLECT;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (lock_q == 16'd0) begin
          state_d = S_COLLECT;
          tries_d = '0;
        end else begin
          lock_d = lock_q - 16'd1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  assign Unlock     = (state_q == S_UNLOCKED);
  assign Locked     = (state_q == S_LOCKED);
  assign Error      = err_q;
  assign DigitCount = cnt_q;

endmodule

// File: tb/tb_passcode_shift_check.sv
// Scenario bench for passcode_shift_check: entry, retries,
// lockout timing, async reset and clear priority.
module tb_passcode_shift_check;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Load = 1'b0;
  logic [3:0]  D = 4'h0;
  logic [15:0] Passcode = 16'h1234;
  logic        Clear = 1'b0;
  logic        Unlock;
  logic        Error;
  logic        Locked;
  logic [2:0]  DigitCount;

  int checks = 0;
  int failures = 0;

  // {expect_unlock, expect_locked}
  logic [1:0] sb_q[$];

  passcode_shift_check #(
    .MAX_TRIES(3),
    .LOCK_CYCLES(16)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Load(Load),
    .D(D),
    .Passcode(Passcode),
    .Clear(Clear),
    .Unlock(Unlock),
    .Error(Error),
    .Locked(Locked),
    .DigitCount(DigitCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic enter_code(input logic [15:0] code,
                            input logic exp_u,
                            input logic exp_l);
    logic [1:0] exp;
    int waitc;
    sb_q.push_back({exp_u, exp_l});
    for (int i = 0; i < 4; i++) begin
      Load = 1'b1;
      D = code[15-4*i -: 4];
      tick();
      Load = 1'b0;
      D = 4'($urandom);
      checks++;
      if (DigitCount !== 3'(i + 1)) begin
        failures++;
        $display("FAIL digit_count got=%0d exp=%0d", DigitCount, i + 1);
      end
      if (i < 3) tick();
    end
    checks++;
    if (Unlock !== 1'b0 || Error !== 1'b0) begin
      failures++;
      $display("FAIL early_result unlock=%b error=%b exp=0/0", Unlock, Error);
    end
    waitc = 0;
    do begin
      tick();
      waitc++;
    end while (Unlock !== 1'b1 && Error !== 1'b1 && waitc < 4);
    exp = sb_q.pop_front();
    checks++;
    if (waitc != 1) begin
      failures++;
      $display("FAIL result_latency got=%0d exp=1", waitc);
    end
    checks++;
    if (Unlock !== exp[1]) begin
      failures++;
      $display("FAIL unlock got=%b exp=%b", Unlock, exp[1]);
    end
    checks++;
    if (Error !== ~exp[1]) begin
      failures++;
      $display("FAIL error got=%b exp=%b", Error, ~exp[1]);
    end
    checks++;
    if (Locked !== exp[0]) begin
      failures++;
      $display("FAIL locked got=%b exp=%b", Locked, exp[0]);
    end
    if (!exp[1]) begin
      checks++;
      if (DigitCount !== 3'd0) begin
        failures++;
        $display("FAIL count_after_err got=%0d exp=0", DigitCount);
      end
    end
    tick();
    checks++;
    if (Error !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse got=%b exp=0", Error);
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    checks++;
    if (Unlock !== 1'b0 || DigitCount !== 3'd0) begin
      failures++;
      $display("FAIL clear unlock=%b count=%0d exp=0/0", Unlock, DigitCount);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Unlock, Error, Locked, DigitCount} !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {Unlock, Error, Locked, DigitCount});
    end
    tick();
    tick();
    Rst = 1'b0;
    tick();
    checks++;
    if ({Unlock, Error, Locked, DigitCount} !== 6'd0) begin
      failures++;
      $display("FAIL post_reset got=%b exp=0", {Unlock, Error, Locked, DigitCount});
    end
  endtask

  task automatic test_unlock();
    Passcode = 16'h1234;
    enter_code(16'h1234, 1'b1, 1'b0);
    Load = 1'b1;
    D = 4'h7;
    tick();
    Load = 1'b0;
    tick();
    checks++;
    if (Unlock !== 1'b1 || Error !== 1'b0) begin
      failures++;
      $display("FAIL unlock_hold unlock=%b error=%b exp=1/0", Unlock, Error);
    end
    do_clear();
  endtask

  task automatic test_held_load();
    Load = 1'b1;
    D = 4'h5;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (DigitCount !== 3'd1) begin
      failures++;
      $display("FAIL held_load got=%0d exp=1", DigitCount);
    end
    do_clear();
    Load = 1'b0;
    tick();
  endtask

  task automatic test_wrong_then_right();
    enter_code(16'h1235, 1'b0, 1'b0);
    enter_code(16'h1234, 1'b1, 1'b0);
    do_clear();
  endtask

  task automatic test_lockout();
    int n;
    int guard;
    bit ignored;
    enter_code(16'h9999, 1'b0, 1'b0);
    enter_code(16'h4321, 1'b0, 1'b0);
    enter_code(16'h0000, 1'b0, 1'b1);
    n = (Locked === 1'b1) ? 2 : 1;
    guard = 0;
    ignored = 1'b1;
    while (Locked === 1'b1 && guard < 100) begin
      Load = ~Load;
      D = 4'($urandom);
      tick();
      guard++;
      if (DigitCount !== 3'd0) ignored = 1'b0;
      if (Locked === 1'b1) n++;
    end
    Load = 1'b0;
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL lock_length got=%0d exp=16", n);
    end
    checks++;
    if (!ignored) begin
      failures++;
      $display("FAIL lock_ignore got=0 exp=1");
    end
    tick();
    checks++;
    if (DigitCount !== 3'd0 || Locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_exit count=%0d locked=%b exp=0/0", DigitCount, Locked);
    end
    enter_code(16'h1234, 1'b1, 1'b0);
    do_clear();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      Load = 1'b1;
      D = 4'(i + 1);
      tick();
      Load = 1'b0;
      tick();
    end
    checks++;
    if (DigitCount !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset_count got=%0d exp=2", DigitCount);
    end
    #2;
    Rst = 1'b1;
    Load = 1'b1;
    D = 4'h7;
    #1;
    checks++;
    if ({Unlock, Error, Locked, DigitCount} !== 6'd0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0", {Unlock, Error, Locked, DigitCount});
    end
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (DigitCount !== 3'd0) begin
      failures++;
      $display("FAIL held_through_reset got=%0d exp=0", DigitCount);
    end
    Load = 1'b0;
    tick();
    Load = 1'b1;
    D = 4'h9;
    tick();
    Load = 1'b0;
    checks++;
    if (DigitCount !== 3'd1) begin
      failures++;
      $display("FAIL reedge_count got=%0d exp=1", DigitCount);
    end
    tick();
    do_clear();
  endtask

  task automatic test_clear_vs_load();
    for (int i = 0; i < 3; i++) begin
      Load = 1'b1;
      D = 4'(i + 1);
      tick();
      Load = 1'b0;
      tick();
    end
    Load = 1'b1;
    D = 4'h4;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    Load = 1'b0;
    checks++;
    if (DigitCount !== 3'd0) begin
      failures++;
      $display("FAIL clear_wins got=%0d exp=0", DigitCount);
    end
    tick();
    tick();
    checks++;
    if (Unlock !== 1'b0 || Error !== 1'b0 || DigitCount !== 3'd0) begin
      failures++;
      $display("FAIL no_check u=%b e=%b c=%0d exp=0/0/0", Unlock, Error, DigitCount);
    end
  endtask

  task automatic test_digit_f();
    Passcode = 16'hF0FF;
    enter_code(16'hFFF0, 1'b0, 1'b0);
    enter_code(16'hF0FF, 1'b1, 1'b0);
    do_clear();
    Passcode = 16'h1234;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_held_load();
    test_wrong_then_right();
    test_lockout();
    test_async_reset();
    test_clear_vs_load();
    test_digit_f();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/passcode_shift_check.md
PASSCODE_SHIFT_CHECK -- requirements
Module: passcode_shift_check

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes before lockout (range 1..7).
REQ-002 SHALL have parameter LOCK_CYCLES, default 16, length of the lockout in Clk cycles (range 1..65535).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port Load  input  1  digit-ready level from the upstream digit register.
REQ-006 SHALL have port D  input  4  digit value from the upstream digit register.
REQ-007 SHALL have port Passcode  input  16  stored code, first digit in [15:12]; quasi-static.
REQ-008 SHALL have port Clear  input  1  synchronous abort, or relock after unlock.
REQ-009 SHALL have port Unlock  output  1  level; correct code accepted.
REQ-010 SHALL have port Error  output  1  one-cycle pulse; wrong code.
REQ-011 SHALL have port Locked  output  1  level; lockout in progress.
REQ-012 SHALL have port DigitCount  output  3  digits collected in the current attempt (0..4).

Function
REQ-013 SHALL detect digit acceptance on the rising edge of Load: Load=1 this cycle and Load=0 the previous cycle, registered as LoadQ. A Load held high SHALL count as one digit only.
REQ-014 SHALL update LoadQ every cycle in every state, so a Load held across a state change never produces a late edge.
REQ-015 SHALL implement a state machine with states COLLECT, CHECK, UNLOCKED and LOCKED.
REQ-016 COLLECT, on an accepted digit: Sr <= {Sr[11:0], D} and DigitCount increments, both visible the cycle after the edge.
REQ-017 COLLECT: when the accepted digit is the 4th, the next state SHALL be CHECK.
REQ-018 CHECK SHALL last exactly one cycle and compare Sr with Passcode.
REQ-019 CHECK on a match: next state UNLOCKED; Unlock=1 from the following cycle; Tries cleared to 0.
REQ-020 CHECK on a mismatch: Error=1 for exactly one cycle (the cycle after CHECK); Tries increments; Sr and DigitCount cleared to 0.
REQ-021 CHECK on a mismatch: the next state SHALL be LOCKED if Tries reaches MAX_TRIES, otherwise COLLECT.
REQ-022 Latency: 4th Load edge at cycle N -> DigitCount=4 at N+1 -> Unlock or Error asserted at N+2.
REQ-023 UNLOCKED: Unlock held at 1, digits ignored; Clear=1 -> COLLECT with Unlock=0, Sr=0 and DigitCount=0 the next cycle.
REQ-024 LOCKED: Locked=1, digits and Clear ignored, 16-bit down-counter loaded with LOCK_CYCLES-1 on entry.
REQ-025 LOCKED exit: at counter 0 -> COLLECT with Tries=0 and Locked=0; Locked SHALL be high for exactly LOCK_CYCLES cycles.
REQ-026 COLLECT with Clear=1: Sr and DigitCount cleared and Tries unchanged; Clear SHALL win over a simultaneous Load edge.
REQ-027 CHECK SHALL ignore Clear and Load edges.
REQ-028 Tries SHALL be a 3-bit counter that never wraps; it saturates at MAX_TRIES.
REQ-029 Error SHALL never be high in the same cycle as Unlock or Locked, except that Error and Locked rise together on the lockout transition.
REQ-030 SHALL never sample D outside the accepted-digit cycle; D=4'hF is treated as an ordinary digit.

Reset
REQ-031 Rst=1 SHALL immediately force, regardless of Clk: state COLLECT, Sr=0, DigitCount=0, Tries=0, lock counter=0, LoadQ=1, Unlock=0, Error=0, Locked=0.
REQ-032 Resetting LoadQ to 1 SHALL ensure that a Load already high when Rst is released does not register as a digit.
REQ-033 Rst asserted mid-attempt, in UNLOCKED or in LOCKED SHALL abandon all progress and lockout; there is no resume.

Verification
REQ-034 Passcode=16'h1234; Load pulses with D=1,2,3,4 -> DigitCount 1..4, Unlock=1 two cycles after the 4th edge, Error never high.
REQ-035 Load held high for 10 cycles with D=5 -> DigitCount=1 only; then Clear=1 -> DigitCount=0, Unlock=0.
REQ-036 Passcode=16'h1234; digits 1,2,3,5 -> one-cycle Error, DigitCount=0, Tries=1; then 1,2,3,4 -> Unlock=1, Tries=0.
REQ-037 Three wrong codes with MAX_TRIES=3 and LOCK_CYCLES=16 -> Locked=1 for exactly 16 cycles, Load edges ignored during lockout, then DigitCount=0 and a correct code unlocks.
REQ-038 Rst pulsed asynchronously between clock edges after 2 digits, with Load held high through release -> all outputs 0 at once, and no digit counted until Load falls and rises again.
REQ-039 Clear and a Load edge in the same COLLECT cycle with DigitCount=3 -> DigitCount=0 the next cycle and no CHECK.
